// File: rtl/mdu_unit_pkg.sv
// Shared MDU definitions: op codes, default busy-cycle counts, sign helper.
// The MADD/MSUB codes always exist; mdu_unit decodes them only under MDU_MADD_EN.
package mdu_unit_pkg;

  typedef enum logic [3:0] {
    MDU_OP_NONE  = 4'd0,
    MDU_OP_MULT  = 4'd1,
    MDU_OP_MULTU = 4'd2,
    MDU_OP_DIV   = 4'd3,
    MDU_OP_DIVU  = 4'd4,
    MDU_OP_MFHI  = 4'd5,
    MDU_OP_MFLO  = 4'd6,
    MDU_OP_MTHI  = 4'd7,
    MDU_OP_MTLO  = 4'd8,
    MDU_OP_MADD  = 4'd9,
    MDU_OP_MADDU = 4'd10,
    MDU_OP_MSUB  = 4'd11,
    MDU_OP_MSUBU = 4'd12
  } mdu_op_e;

  localparam int MDU_MULT_CYCLES_DEF = 5;
  localparam int MDU_DIV_CYCLES_DEF  = 10;

  function automatic logic [31:0] neg_if(input logic neg, input logic [31:0] val);
    return neg ? (~val + 32'd1) : val;
  endfunction

endpackage

// File: rtl/mdu_unit.sv
// EX-stage multiply/divide unit owning HI/LO, with a down-counting busy timer.
// Define MDU_MADD_EN to add MADD/MADDU/MSUB/MSUBU (accumulate into {HI,LO}).
module mdu_unit
  import mdu_unit_pkg::*;
#(
  parameter int MULT_CYCLES = MDU_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MDU_DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] iA1,
  input  logic [31:0] iA2,
  input  logic [3:0]  iop,
  input  logic        icancel,
  output logic        obusy,
  output logic [31:0] ordata
);

  logic [31:0] r_hi, r_lo;
  logic [31:0] r_phi, r_plo;
  logic        r_pskip;
  logic [3:0]  r_cnt;

  mdu_op_e     w_op;
  logic        w_is_start, w_start, w_div0, w_idle;
  logic [3:0]  w_cycles;
  logic [31:0] w_phi, w_plo;
  logic [63:0] w_prod_s, w_prod_u;
  logic [31:0] w_divisor, w_a_mag, w_b_mag, w_qmag, w_rmag;

  assign w_op   = mdu_op_e'(iop);
  assign obusy  = (r_cnt != 4'd0);
  assign w_idle = !icancel && !obusy;

  assign w_prod_s = {{32{iA1[31]}}, iA1} * {{32{iA2[31]}}, iA2};
  assign w_prod_u = {32'd0, iA1} * {32'd0, iA2};

  // Divisor forced to 1 on zero so the dividers never see /0; the result is discarded anyway.
  assign w_divisor = (iA2 == 32'd0) ? 32'd1 : iA2;
  assign w_a_mag   = neg_if(iA1[31], iA1);
  assign w_b_mag   = neg_if(w_divisor[31], w_divisor);
  assign w_qmag    = w_a_mag / w_b_mag;
  assign w_rmag    = w_a_mag % w_b_mag;

  always_comb begin
    w_is_start = 1'b0;
    w_cycles   = 4'd0;
    w_phi      = 32'd0;
    w_plo      = 32'd0;
    w_div0     = 1'b0;
    case (w_op)
      MDU_OP_MULT: begin
        w_is_start     = 1'b1;
        w_cycles       = 4'(MULT_CYCLES);
        {w_phi, w_plo} = w_prod_s;
      end
      MDU_OP_MULTU: begin
        w_is_start     = 1'b1;
        w_cycles       = 4'(MULT_CYCLES);
        {w_phi, w_plo} = w_prod_u;
      end
      MDU_OP_DIV: begin
        // Magnitude divide then re-sign; 0x80000000 / -1 wraps to 0x80000000 rem 0.
        w_is_start = 1'b1;
        w_cycles   = 4'(DIV_CYCLES);
        w_div0     = (iA2 == 32'd0);
        w_plo      = neg_if(iA1[31] ^ iA2[31], w_qmag);
        w_phi      = neg_if(iA1[31], w_rmag);
      end
      MDU_OP_DIVU: begin
        w_is_start = 1'b1;
        w_cycles   = 4'(DIV_CYCLES);
        w_div0     = (iA2 == 32'd0);
        w_plo      = iA1 / w_divisor;
        w_phi      = iA1 % w_divisor;
      end
`ifdef MDU_MADD_EN
      MDU_OP_MADD: begin
        w_is_start     = 1'b1;
        w_cycles       = 4'(MULT_CYCLES);
        {w_phi, w_plo} = {r_hi, r_lo} + w_prod_s;
      end
      MDU_OP_MADDU: begin
        w_is_start     = 1'b1;
        w_cycles       = 4'(MULT_CYCLES);
        {w_phi, w_plo} = {r_hi, r_lo} + w_prod_u;
      end
      MDU_OP_MSUB: begin
        w_is_start     = 1'b1;
        w_cycles       = 4'(MULT_CYCLES);
        {w_phi, w_plo} = {r_hi, r_lo} - w_prod_s;
      end
      MDU_OP_MSUBU: begin
        w_is_start     = 1'b1;
        w_cycles       = 4'(MULT_CYCLES);
        {w_phi, w_plo} = {r_hi, r_lo} - w_prod_u;
      end
`endif
      default: ;
    endcase
  end

  assign w_start = w_is_start && w_idle;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt   <= 4'd0;
      r_phi   <= 32'd0;
      r_plo   <= 32'd0;
      r_pskip <= 1'b0;
    end else if (w_start) begin
      r_cnt   <= w_cycles;
      r_phi   <= w_phi;
      r_plo   <= w_plo;
      r_pskip <= w_div0;
    end else if (r_cnt != 4'd0) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  // Commit and MTHI/MTLO can never coincide: commit only happens while busy.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hi <= 32'd0;
      r_lo <= 32'd0;
    end else if (r_cnt == 4'd1) begin
      if (!r_pskip) begin
        r_hi <= r_phi;
        r_lo <= r_plo;
      end
    end else if (w_idle && (w_op == MDU_OP_MTHI)) begin
      r_hi <= iA1;
    end else if (w_idle && (w_op == MDU_OP_MTLO)) begin
      r_lo <= iA1;
    end
  end

  always_comb begin
    ordata = 32'd0;
    if (w_op == MDU_OP_MFHI) ordata = r_hi;
    else if (w_op == MDU_OP_MFLO) ordata = r_lo;
  end

endmodule
